reg_file_sb: RTL

//  Parametrised 2-read/1-write register file for the 32bmp datapath with a
//  per-register lock scoreboard, write-to-read bypass and a post-reset clear sweep.

---
 rtl/reg_file_pkg.sv | 20 ++
 rtl/reg_lock_tbl.sv | 41 ++++
 rtl/reg_file_sb.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the reg_file_sb register file slice.
//  - state_t    : clear-sweep FSM states
//  - DEF_DATA_W : default register width
//  - DEF_ADDR_W : default index width
//  - null_idx() : the all-ones index that reads as zero and ignores writes/locks
package reg_file_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   function automatic int unsigned null_idx(input int unsigned addr_w);
      return (32'd1 << addr_w) - 32'd1;
   endfunction

endpackage

// File: rtl/reg_lock_tbl.sv
// Per-register lock scoreboard.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset (clears all locks)
//  set_enbl, set_addr    reserve an index (wins over a clear of the same index)
//  clr_enbl, clr_addr    release an index
//  look_addr0/1          combinational lookup indices
//  lock0/1               lock bit of the looked-up index
module reg_lock_tbl #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_enbl,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_enbl,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] look_addr0,
   input  logic [ADDR_W-1:0] look_addr1,
   output logic              lock0,
   output logic              lock1
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] lock_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; the set is written after the clear so it wins on a collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q <= '0;
      end else begin
         if (clr_enbl) lock_q[clr_addr] <= 1'b0;
         if (set_enbl) lock_q[set_addr] <= 1'b1;
      end
   end

   assign lock0 = lock_q[look_addr0];
   assign lock1 = lock_q[look_addr1];

endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with lock scoreboard, write-to-read bypass
// and a post-reset clear sweep.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  rd_addr0/1            read indices
//  rd_dat0/1             combinational read data
//  wrt_enbl/addr/dat     write port; a write also releases the index's lock
//  lock_enbl/addr        reserve an index as a pending destination
//  busy0/1               read index holds a pending (locked) value
//  init_done             clear sweep finished, block accepts traffic
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                BYPASS   = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr0,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [DATA_W-1:0] rd_dat0,
   output logic [DATA_W-1:0] rd_dat1,
   input  logic              wrt_enbl,
   input  logic [ADDR_W-1:0] wrt_addr,
   input  logic [DATA_W-1:0] wrt_dat,
   input  logic              lock_enbl,
   input  logic [ADDR_W-1:0] lock_addr,
   output logic              busy0,
   output logic              busy1,
   output logic              init_done
);

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] NULL_IDX = ADDR_W'(null_idx(ADDR_W));

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              ready;
   logic              wrt_ok;
   logic              lock_ok;
   logic              lock_hit0, lock_hit1;

   assign ready     = (state_q == ST_READY);
   assign init_done = ready;
   assign wrt_ok    = ready && wrt_enbl  && (wrt_addr  != NULL_IDX);
   assign lock_ok   = ready && lock_enbl && (lock_addr != NULL_IDX);

   // Sweep FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: combinational blocks assign every output a default first so no
   // path leaves a signal unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == NULL_IDX) state_d = ST_READY;
      end
   end

   // NOTE: the storage array has no reset; the sweep initialises it, which
   // keeps it mappable to plain RAM/flops without a reset tree.
   always_ff @(posedge clk) begin
      if (!ready) begin
         mem[cnt_q] <= INIT_VAL;
      end else if (wrt_ok) begin
         mem[wrt_addr] <= wrt_dat;
      end
   end

   // A write releases its lock; a lock in the same cycle re-reserves it for
   // the younger instruction (set priority inside the table).
   reg_lock_tbl #(.ADDR_W(ADDR_W)) u_lock_tbl (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_enbl   (lock_ok),
      .set_addr   (lock_addr),
      .clr_enbl   (wrt_ok),
      .clr_addr   (wrt_addr),
      .look_addr0 (rd_addr0),
      .look_addr1 (rd_addr1),
      .lock0      (lock_hit0),
      .lock1      (lock_hit1)
   );

   // Read muxes: INIT blanks data and reports busy; the null index reads
   // as an idle zero; a same-cycle write to the index is forwarded.
   always_comb begin
      rd_dat0 = '0;
      busy0   = 1'b1;
      if (ready) begin
         busy0 = 1'b0;
         if (rd_addr0 != NULL_IDX) begin
            if (BYPASS != 0 && wrt_enbl && wrt_addr == rd_addr0) begin
               rd_dat0 = wrt_dat;
            end else begin
               rd_dat0 = mem[rd_addr0];
               busy0   = lock_hit0;
            end
         end
      end
   end

   always_comb begin
      rd_dat1 = '0;
      busy1   = 1'b1;
      if (ready) begin
         busy1 = 1'b0;
         if (rd_addr1 != NULL_IDX) begin
            if (BYPASS != 0 && wrt_enbl && wrt_addr == rd_addr1) begin
               rd_dat1 = wrt_dat;
            end else begin
               rd_dat1 = mem[rd_addr1];
               busy1   = lock_hit1;
            end
         end
      end
   end

endmodule
